// File: rtl/preif_fetch_group.sv
// preif_fetch_group: pre-IF stage that issues FETCH_W-aligned fetch groups, latches stalled
// redirects, replays flushes that hit a busy ICache and parks on fetch exceptions. Optional: PREIF_ITLB_EN.
`ifndef NO_EX
`define NO_EX 5'h1f
`endif
`ifndef AdEL
`define AdEL 5'h04
`endif
`ifndef ITLB_EX_Refill
`define ITLB_EX_Refill 5'h02
`endif
`ifndef ITLB_EX_Invalid
`define ITLB_EX_Invalid 5'h1b
`endif

module preif_fetch_group #(
    parameter int unsigned FETCH_W       = 2,
    parameter logic [31:0] RESET_PC      = 32'hBFC00000,
    parameter logic [31:0] GENERAL_EX_PC = 32'hBFC00380,
    parameter logic [31:0] REFILL_EX_PC  = 32'hBFC00200,
    parameter int unsigned CW            = $clog2(FETCH_W) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fs_allowin,
    input  logic          br_stall,
    input  logic          br_taken,
    input  logic [31:0]   br_target,
    input  logic          flush,
    input  logic          flush_refill,
    input  logic          eret,
    input  logic [31:0]   epc,
    input  logic          icache_busy,
`ifdef PREIF_ITLB_EN
    input  logic          itlb_found,
    input  logic          itlb_v,
    input  logic [19:0]   itlb_pfn,
`endif
    output logic          req_valid,
    output logic [31:0]   req_paddr,
    output logic [CW-1:0] req_count,
    output logic          ps_to_fs_valid,
    output logic [31:0]   ps_pc,
    output logic [CW-1:0] ps_count,
    output logic          ps_bdd,
    output logic          ps_ex,
    output logic [4:0]    ps_exctype
);

    typedef enum logic [1:0] {RUN, REPLAY, HOLD_EX} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   redir_pc_q, redir_pc_d;
    logic          redir_vld_q, redir_vld_d;

    logic [31:0]   fetch_pc, grp_idx, seq_pc, paddr;
    logic [CW-1:0] grp_cnt;
    logic [4:0]    ex_code;
    logic          adel, ex_any, active, advance, handoff, reload;

    // A latched redirect is fetched directly, so a branch seen while stalled
    // issues its target on the first unstalled cycle.
    assign fetch_pc = redir_vld_q ? redir_pc_q : pc_q;

    always_comb begin
        grp_idx = (fetch_pc >> 2) & 32'(FETCH_W - 1);
        grp_cnt = CW'(32'(FETCH_W) - grp_idx);
        seq_pc  = fetch_pc + (32'(grp_cnt) << 2);
    end

    assign adel = (fetch_pc[1:0] != 2'b00);

`ifdef PREIF_ITLB_EN
    always_comb begin
        if (adel)
            ex_code = `AdEL;
        else if (!itlb_found)
            ex_code = `ITLB_EX_Refill;
        else if (!itlb_v)
            ex_code = `ITLB_EX_Invalid;
        else
            ex_code = `NO_EX;
    end
    assign paddr = {itlb_pfn, fetch_pc[11:0]};
`else
    assign ex_code = adel ? `AdEL : `NO_EX;
    assign paddr   = fetch_pc & 32'h1FFFFFFF;
`endif

    assign ex_any  = (ex_code != `NO_EX);
    assign reload  = flush | eret;
    // REPLAY with the ICache free behaves exactly like RUN for that cycle.
    assign active  = !reset && ((state_q == RUN) || ((state_q == REPLAY) && !icache_busy));
    assign advance = active && !icache_busy && fs_allowin && !br_stall && !ex_any;
    assign handoff = active && ex_any && fs_allowin;

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN, REPLAY: begin
                if (handoff)
                    state_d = HOLD_EX;
                else if ((state_q == REPLAY) && !icache_busy)
                    state_d = RUN;
            end
            HOLD_EX: state_d = HOLD_EX;
            default: state_d = RUN;
        endcase
        if (reload)
            state_d = icache_busy ? REPLAY : RUN;
    end

    always_comb begin
        req_valid      = advance;
        ps_to_fs_valid = advance || handoff;
        req_paddr      = reset ? '0 : paddr;
        req_count      = reset ? '0 : (ex_any ? CW'(1) : grp_cnt);
        ps_count       = req_count;
        ps_pc          = reset ? RESET_PC : fetch_pc;
        ps_bdd         = advance && redir_vld_q;
        ps_ex          = active && ex_any;
        ps_exctype     = ps_ex ? ex_code : `NO_EX;
    end

    always_comb begin
        pc_d        = pc_q;
        redir_pc_d  = redir_pc_q;
        redir_vld_d = redir_vld_q;
        if (eret) begin
            pc_d        = epc;
            redir_vld_d = 1'b0;
        end else if (flush) begin
            pc_d        = flush_refill ? REFILL_EX_PC : GENERAL_EX_PC;
            redir_vld_d = 1'b0;
        end else begin
            if (advance) begin
                pc_d        = seq_pc;
                redir_vld_d = 1'b0;
            end
            if (br_taken) begin
                redir_pc_d  = br_target;
                redir_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            redir_pc_q  <= '0;
            redir_vld_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            redir_pc_q  <= redir_pc_d;
            redir_vld_q <= redir_vld_d;
        end
    end

endmodule

// File: tb/tb_preif_fetch_group.sv
// Scoreboard bench for preif_fetch_group (FETCH_W=4 main DUT, FETCH_W=2 wrap DUT).
`ifndef NO_EX
`define NO_EX 5'h1f
`endif
`ifndef AdEL
`define AdEL 5'h04
`endif
`ifndef ITLB_EX_Refill
`define ITLB_EX_Refill 5'h02
`endif
`ifndef ITLB_EX_Invalid
`define ITLB_EX_Invalid 5'h1b
`endif

module tb_preif_fetch_group;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] paddr;
        logic [31:0] cnt;
        logic        bdd;
        logic        ex;
        logic [4:0]  code;
        logic        rv;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fs_allowin = 1'b1, br_stall = 1'b0, br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        flush = 1'b0, flush_refill = 1'b0, eret = 1'b0;
    logic [31:0] epc = '0;
    logic        icache_busy = 1'b0;
`ifdef PREIF_ITLB_EN
    logic        itlb_found = 1'b1, itlb_v = 1'b1;
    logic [19:0] itlb_pfn = '0;
`endif

    logic        req_valid, ps_to_fs_valid, ps_bdd, ps_ex;
    logic [31:0] req_paddr, ps_pc;
    logic [2:0]  req_count, ps_count;
    logic [4:0]  ps_exctype;

    logic        fs_allowin2 = 1'b0, eret2 = 1'b0;
    logic [31:0] epc2 = '0;
    logic        req_valid2, ps_to_fs_valid2, ps_bdd2, ps_ex2;
    logic [31:0] req_paddr2, ps_pc2;
    logic [1:0]  req_count2, ps_count2;
    logic [4:0]  ps_exctype2;

    always #5 clk = ~clk;

    preif_fetch_group #(.FETCH_W(4)) dut (
        .clk(clk), .reset(reset), .fs_allowin(fs_allowin), .br_stall(br_stall),
        .br_taken(br_taken), .br_target(br_target), .flush(flush),
        .flush_refill(flush_refill), .eret(eret), .epc(epc), .icache_busy(icache_busy),
`ifdef PREIF_ITLB_EN
        .itlb_found(itlb_found), .itlb_v(itlb_v), .itlb_pfn(itlb_pfn),
`endif
        .req_valid(req_valid), .req_paddr(req_paddr), .req_count(req_count),
        .ps_to_fs_valid(ps_to_fs_valid), .ps_pc(ps_pc), .ps_count(ps_count),
        .ps_bdd(ps_bdd), .ps_ex(ps_ex), .ps_exctype(ps_exctype)
    );

    preif_fetch_group #(.FETCH_W(2)) dut2 (
        .clk(clk), .reset(reset), .fs_allowin(fs_allowin2), .br_stall(1'b0),
        .br_taken(1'b0), .br_target(32'h0), .flush(1'b0),
        .flush_refill(1'b0), .eret(eret2), .epc(epc2), .icache_busy(1'b0),
`ifdef PREIF_ITLB_EN
        .itlb_found(1'b1), .itlb_v(1'b1), .itlb_pfn(20'h0),
`endif
        .req_valid(req_valid2), .req_paddr(req_paddr2), .req_count(req_count2),
        .ps_to_fs_valid(ps_to_fs_valid2), .ps_pc(ps_pc2), .ps_count(ps_count2),
        .ps_bdd(ps_bdd2), .ps_ex(ps_ex2), .ps_exctype(ps_exctype2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] exp_paddr(input logic [31:0] pc);
`ifdef PREIF_ITLB_EN
        return {itlb_pfn, pc[11:0]};
`else
        return pc & 32'h1FFF_FFFF;
`endif
    endfunction

    task automatic expect_grp(input string tag, input logic [31:0] pc, input int cnt,
                              input logic bdd, input logic [4:0] code);
        exp_t e;
        e.tag   = tag;
        e.pc    = pc;
        e.paddr = exp_paddr(pc);
        e.cnt   = 32'(cnt);
        e.bdd   = bdd;
        e.code  = code;
        e.ex    = (code != `NO_EX);
        e.rv    = !e.ex;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (ps_to_fs_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_issue", {31'b0, ps_to_fs_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq({e.tag, ".pc"}, ps_pc, e.pc);
                check_eq({e.tag, ".count"}, 32'(ps_count), e.cnt);
                check_eq({e.tag, ".req_count"}, 32'(req_count), e.cnt);
                check_eq({e.tag, ".bdd"}, 32'(ps_bdd), 32'(e.bdd));
                check_eq({e.tag, ".ex"}, 32'(ps_ex), 32'(e.ex));
                check_eq({e.tag, ".exctype"}, 32'(ps_exctype), 32'(e.code));
                check_eq({e.tag, ".req_valid"}, 32'(req_valid), 32'(e.rv));
                if (e.rv)
                    check_eq({e.tag, ".paddr"}, req_paddr, e.paddr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_tick(input string tag);
        @(negedge clk);
        check_eq({tag, ".req_valid"}, 32'(req_valid), 32'd0);
        check_eq({tag, ".ps_valid"}, 32'(ps_to_fs_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(negedge clk);
        check_eq("rst.req_valid", 32'(req_valid), 32'd0);
        check_eq("rst.ps_valid", 32'(ps_to_fs_valid), 32'd0);
        check_eq("rst.ps_pc", ps_pc, 32'hBFC0_0000);
        check_eq("rst.exctype", 32'(ps_exctype), 32'(`NO_EX));
        check_eq("rst.paddr", req_paddr, 32'd0);
        check_eq("rst.count", 32'(ps_count), 32'd0);
        check_eq("rst.ex_bdd", {30'b0, ps_ex, ps_bdd}, 32'd0);
        check_eq("rst.ps_pc2", ps_pc2, 32'hBFC0_0000);
        @(posedge clk);
        #1;
        reset = 1'b0;

        expect_grp("seq0", 32'hBFC0_0000, 4, 1'b0, `NO_EX);
        expect_grp("seq1", 32'hBFC0_0010, 4, 1'b0, `NO_EX);
        tick(); tick();

        fs_allowin = 1'b0; br_taken = 1'b1; br_target = 32'hBFC0_0008;
        tick();
        br_taken = 1'b0; fs_allowin = 1'b1;
        expect_grp("jmp8", 32'hBFC0_0008, 2, 1'b1, `NO_EX);
        expect_grp("after8", 32'hBFC0_0010, 4, 1'b0, `NO_EX);
        tick(); tick();

        icache_busy = 1'b1; br_taken = 1'b1; br_target = 32'h8000_1000;
        idle_tick("busy0");
        br_taken = 1'b0;
        idle_tick("busy1"); idle_tick("busy2");
        icache_busy = 1'b0;
        expect_grp("redir", 32'h8000_1000, 4, 1'b1, `NO_EX);
        expect_grp("redir_seq", 32'h8000_1010, 4, 1'b0, `NO_EX);
        tick(); tick();

        fs_allowin = 1'b0; br_taken = 1'b1; br_target = 32'h8000_3000;
        tick();
        br_target = 32'h8000_3008;
        tick();
        br_taken = 1'b0; fs_allowin = 1'b1;
        expect_grp("overwrite", 32'h8000_3008, 2, 1'b1, `NO_EX);
        tick();

        icache_busy = 1'b1; flush = 1'b1; flush_refill = 1'b1;
        br_taken = 1'b1; br_target = 32'h8000_2000;
        idle_tick("flush_busy");
        flush = 1'b0; flush_refill = 1'b0; br_taken = 1'b0;
        idle_tick("replay0"); idle_tick("replay1");
        icache_busy = 1'b0;
        expect_grp("replay_pc", 32'hBFC0_0200, 4, 1'b0, `NO_EX);
        expect_grp("replay_seq", 32'hBFC0_0210, 4, 1'b0, `NO_EX);
        tick(); tick();

        fs_allowin = 1'b0; br_taken = 1'b1; br_target = 32'h8000_0002;
        tick();
        br_taken = 1'b0; fs_allowin = 1'b1;
        expect_grp("adel", 32'h8000_0002, 1, 1'b0, `AdEL);
        tick();
        idle_tick("hold0"); idle_tick("hold1");
        eret = 1'b1; epc = 32'h8000_0100;
        idle_tick("eret_cyc");
        eret = 1'b0;
        expect_grp("eret_resume", 32'h8000_0100, 4, 1'b0, `NO_EX);
        tick();

        br_stall = 1'b1;
        idle_tick("br_stall");
        br_stall = 1'b0; fs_allowin = 1'b0;
        idle_tick("no_allowin");

        flush = 1'b1;
        tick();
        flush = 1'b0; fs_allowin = 1'b1;
        expect_grp("flush_gen", 32'hBFC0_0380, 4, 1'b0, `NO_EX);
        tick();
        fs_allowin = 1'b0;

`ifdef PREIF_ITLB_EN
        eret = 1'b1; epc = 32'h0040_0ABC;
        tick();
        eret = 1'b0; itlb_found = 1'b0; fs_allowin = 1'b1;
        expect_grp("tlb_refill", 32'h0040_0ABC, 1, 1'b0, `ITLB_EX_Refill);
        tick();
        eret = 1'b1; fs_allowin = 1'b0; itlb_found = 1'b1; itlb_v = 1'b0;
        tick();
        eret = 1'b0; fs_allowin = 1'b1;
        expect_grp("tlb_invalid", 32'h0040_0ABC, 1, 1'b0, `ITLB_EX_Invalid);
        tick();
        eret = 1'b1; fs_allowin = 1'b0; epc = 32'h0040_0ABE; itlb_found = 1'b0;
        tick();
        eret = 1'b0; fs_allowin = 1'b1;
        expect_grp("adel_prio", 32'h0040_0ABE, 1, 1'b0, `AdEL);
        tick();
        eret = 1'b1; fs_allowin = 1'b0; epc = 32'h0040_0ABC;
        itlb_found = 1'b1; itlb_v = 1'b1; itlb_pfn = 20'h12345;
        tick();
        eret = 1'b0; fs_allowin = 1'b1;
        expect_grp("tlb_hit", 32'h0040_0ABC, 1, 1'b0, `NO_EX);
        tick();
        check_eq("tlb_hit_paddr_const", exp_paddr(32'h0040_0ABC), 32'h1234_5ABC);
        fs_allowin = 1'b0;
`endif

        eret2 = 1'b1; epc2 = 32'hFFFF_FFF8;
        tick();
        eret2 = 1'b0; fs_allowin2 = 1'b1;
        @(negedge clk);
        check_eq("wrap.pc", ps_pc2, 32'hFFFF_FFF8);
        check_eq("wrap.count", 32'(ps_count2), 32'd2);
        check_eq("wrap.req_valid", 32'(req_valid2), 32'd1);
        @(posedge clk);
        #1;
        fs_allowin2 = 1'b0;
        @(negedge clk);
        check_eq("wrap.next_pc", ps_pc2, 32'h0000_0000);
        check_eq("wrap.next_count", 32'(ps_count2), 32'd2);
        @(posedge clk);
        #1;

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
